// File: rtl/maze_pkg.sv
// Shared types and constants for the MAZE node switch allocator.
package maze_pkg;

    localparam int NPORT = 5;
    localparam int PTR_W = 3;

    localparam int DIR_N = 0;
    localparam int DIR_W = 1;
    localparam int DIR_S = 2;
    localparam int DIR_E = 3;
    localparam int DIR_B = 4;

    // Where this node sits relative to a power-gated (faulty) neighbour x.
    typedef enum logic [3:0] {
        NORMAL,
        N_OF_X,
        S_OF_X,
        E_OF_X,
        W_OF_X,
        NE_OF_X,
        SE_OF_X,
        SW_OF_X,
        NW_OF_X
    } fault_pos_t;

    typedef logic [NPORT-1:0] route_req_t;
    typedef logic [PTR_W-1:0] port_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } alloc_st_t;

    function automatic port_idx_t wrap_inc(input port_idx_t p);
        return (p == port_idx_t'(NPORT - 1)) ? '0 : p + port_idx_t'(1);
    endfunction

endpackage

// File: rtl/maze_rr_arb5.sv
// Five-request round-robin arbiter; the pointer moves past the winner on every grant.
module maze_rr_arb5
    import maze_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req,
    output logic [4:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_any
);

    port_idx_t ptr;
    port_idx_t cand;

    // Search starts at ptr and walks upward, wrapping 4 -> 0.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = ptr;
        for (int k = 0; k < NPORT; k++) begin
            if (!gnt_any && req[cand]) begin
                gnt_any   = 1'b1;
                gnt_idx   = cand;
                gnt[cand] = 1'b1;
            end
            cand = wrap_inc(cand);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= wrap_inc(gnt_idx);
        end
    end

endmodule

// File: rtl/maze_switch_allocator.sv
// Switch allocator for one MAZE mesh node: five input heads competing for five
// crossbar outputs, with multicast served piecemeal until every requested output fired.
//
//   state  | meaning
//   IDLE   | no head loaded; loads route_req & ~out_block when in_valid is set
//   ACTIVE | pending mask nonzero; competes for each output still in the mask
//   DONE   | head fully served, in_pop is out; in_valid ignored for this cycle
module maze_switch_allocator
    import maze_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  in_valid,
    input  logic [24:0] in_route_req,
    input  logic [4:0]  out_ready,
    input  logic [4:0]  out_block,
    output logic [4:0]  out_valid,
    output logic [14:0] out_sel,
    output logic [4:0]  in_pop,
    output logic [4:0]  err_drop
);

    alloc_st_t st     [NPORT];
    alloc_st_t st_nxt [NPORT];

    logic [NPORT-1:0][NPORT-1:0] mask;      // [input][output]
    logic [NPORT-1:0][NPORT-1:0] mask_nxt;
    logic [NPORT-1:0][NPORT-1:0] served;    // [input][output]
    logic [NPORT-1:0][NPORT-1:0] arb_req;   // [output][input]
    logic [NPORT-1:0][NPORT-1:0] arb_gnt;   // [output][input]
    logic [NPORT-1:0][PTR_W-1:0] gnt_idx;
    logic [NPORT-1:0]            gnt_any;
    logic [NPORT-1:0]            eligible;
    logic [NPORT-1:0]            pop_nxt;
    logic [NPORT-1:0]            drop_nxt;

    assign eligible = out_ready & ~out_block;

    always_comb begin
        arb_req = '0;
        served  = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                arb_req[o][i] = eligible[o] && (st[i] == ACTIVE) && mask[i][o];
                served[i][o]  = arb_gnt[o][i];
            end
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_arb
        maze_rr_arb5 u_arb (
            .clk     (clk),
            .rst     (rst),
            .req     (arb_req[o]),
            .gnt     (arb_gnt[o]),
            .gnt_idx (gnt_idx[o]),
            .gnt_any (gnt_any[o])
        );
    end

    always_comb begin
        mask_nxt = mask;
        pop_nxt  = '0;
        drop_nxt = '0;
        for (int i = 0; i < NPORT; i++) begin
            st_nxt[i] = st[i];
            case (st[i])
                IDLE: begin
                    if (in_valid[i]) begin
                        mask_nxt[i] = in_route_req[NPORT*i +: NPORT] & ~out_block;
                        // An all-zero load (empty or fully blocked) is popped right away.
                        if (mask_nxt[i] == '0) begin
                            st_nxt[i]   = DONE;
                            pop_nxt[i]  = 1'b1;
                            drop_nxt[i] = 1'b1;
                        end else begin
                            st_nxt[i]   = ACTIVE;
                            drop_nxt[i] = |(in_route_req[NPORT*i +: NPORT] & out_block);
                        end
                    end
                end
                ACTIVE: begin
                    mask_nxt[i] = mask[i] & ~served[i];
                    if (mask_nxt[i] == '0) begin
                        st_nxt[i]  = DONE;
                        pop_nxt[i] = 1'b1;
                    end
                end
                DONE:    st_nxt[i] = IDLE;
                default: st_nxt[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPORT; i++) begin
                st[i] <= IDLE;
            end
            mask      <= '0;
            out_valid <= '0;
            out_sel   <= '0;
            in_pop    <= '0;
            err_drop  <= '0;
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                st[i] <= st_nxt[i];
            end
            mask      <= mask_nxt;
            out_valid <= gnt_any;
            for (int o = 0; o < NPORT; o++) begin
                if (gnt_any[o]) begin
                    out_sel[PTR_W*o +: PTR_W] <= gnt_idx[o];
                end
            end
            in_pop   <= pop_nxt;
            err_drop <= drop_nxt;
        end
    end

endmodule

// File: doc/maze_switch_allocator.md
Name: maze_switch_allocator

Overview:
Switch allocator for one MAZE mesh node. It arbitrates the five input-buffer heads (N,W,S,E,B) for the five crossbar outputs, using each head's 5-bit route_req from the pre-buffer router. It supports multicast/broadcast fan-out by partial serving: a head packet is released only after every requested output has carried it once. A config mask blocks outputs facing a power-gated (faulty) neighbour.

Parameters:
NPORT, 5, number of ports; fixed index order N=0, W=1, S=2, E=3, B=4
PTR_W, 3, width of a round-robin pointer and of each out_sel field

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  5  input i has a head packet; held until in_pop[i]
in_route_req  input  25  [5i+4:5i] is input i route_req [N,W,S,E,B], sampled only on load
out_ready  input  5  output o can accept a packet this cycle
out_block  input  5  config mask; output o must never be granted (static except during reset)
out_valid  output  5  registered; output o carries a packet this cycle
out_sel  output  15  registered; [3o+2:3o] is the source input index for output o
in_pop  output  5  registered one-cycle pulse; input i fully served, upstream pops at this edge
err_drop  output  5  registered one-cycle pulse; input i had blocked or empty request bits discarded

Behaviour:
- Reset (async, rst=1): out_valid=0, out_sel=0, in_pop=0, err_drop=0. All pending masks are 0, all input FSMs are IDLE, all RR pointers are 0. Reset mid-operation discards partial multicasts without popping them.
- Per-input FSM IDLE -> ACTIVE -> DONE -> IDLE:
  - IDLE with in_valid[i]=1: load mask = route_req & ~out_block.
  - If the loaded mask is nonzero: go ACTIVE. err_drop[i] pulses next cycle if route_req & out_block was nonzero.
  - If the loaded mask is zero: go DONE directly, with in_pop[i]=1 and err_drop[i]=1 next cycle.
  - ACTIVE: the input competes for each output whose mask bit is set. A granted bit is cleared at the edge.
  - When the last bit is cleared: go DONE, with in_pop[i]=1 in the same cycle as the final out_valid.
  - DONE: in_valid is ignored (the stale head is still being popped). Next state is IDLE.
- Allocation is combinational from registered state; grants are registered into out_valid/out_sel.
  - Output o is eligible iff out_ready[o]=1 and out_block[o]=0.
  - Candidates are ACTIVE inputs with mask[i][o]=1.
- Round-robin per output: search starts at ptr[o] and proceeds upward, wrapping 4 -> 0. On grant to input k, ptr[o] = (k+1) mod 5, so 4 wraps to 0. The pointer is unchanged when there is no grant.
- One input may win several outputs in the same cycle (parallel multicast fan-out). Each output grants at most one input.
- U-turns (input i to output i) are not checked; B->B is a legal local loopback.
- Latency: load at edge 1, grant visible on out_valid after edge 2, in_pop coincides. Minimum head-to-head spacing per input is 3 cycles.
- out_sel is held at its last value when out_valid=0.
- If out_ready drops, ungranted bits stay pending indefinitely; there is no timeout.
- A change of out_block while a mask is ACTIVE is undefined; it is legal only under rst.

Decomposition:
- maze_pkg holds:
  - DIR_N..DIR_B index constants and NPORT
  - fault-position encodings NORMAL..NW_OF_x
  - typedef route_req_t (5-bit)
  - typedef port_idx_t (3-bit)
  - FSM state enum alloc_st_t {IDLE, ACTIVE, DONE}
- Sub-module maze_rr_arb5: 5-request round-robin arbiter with pointer register, grant one-hot, grant index and advance-on-grant. It is instantiated once per output.

Test Plan:
- Unicast: cycle 0, in_valid[0]=1, req=5'b01000 (E), all out_ready=1. At cycle 2, out_valid=5'b01000, out_sel[11:9]=0, in_pop=5'b00001. All outputs are 0 at cycle 3.
- Contention: inputs W(1) and S(2) both request E, loaded together. E grants W then S on consecutive cycles; ptr[E] goes 0 -> 2 -> 3. in_pop[1] and in_pop[2] pulse one cycle apart.
- Broadcast: input B(4) req=5'b11111, with out_ready[S]=0 for 3 cycles. N, W, E and B fire at cycle 2. S fires on the cycle after out_ready[S] rises. in_pop[4] pulses only with the S grant.
- Blocking: out_block=5'b00100, input N req=5'b00110. Only W is granted. err_drop[0]=1 at cycle 1. in_pop[0] pulses with the W grant.
- Empty request: in_valid[3]=1, req=0. At cycle 1, in_pop[3]=1 and err_drop[3]=1, with no out_valid.
- Reset mid-multicast: assert rst after a partial broadcast has fired 2 of 5 outputs. All outputs drop to 0 immediately, with no in_pop. After release, the still-valid head reloads and fires all 5 outputs.
